// File: rtl/onehot_dispatch_decoder_if.sv
// onehot_dispatch_decoder_if: code handshake and one-hot line bundle
// master drives in_valid/in_code/ack and observes in_ready/y/busy/acked/timeout; slave is the decoder side
interface onehot_dispatch_decoder_if;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] ack;
  logic [7:0] y;
  logic       busy;
  logic       acked;
  logic       timeout;
  modport master(output in_valid, in_code, ack, input in_ready, y, busy, acked, timeout);
  modport slave(input in_valid, in_code, ack, output in_ready, y, busy, acked, timeout);
endinterface

// File: rtl/onehot_dispatch_decoder.sv
// onehot_dispatch_decoder: registered 3-to-8 decoder holding one line until ack or timeout, then a guard gap
// ports: clk, rst_n (async active-low), en (sync abort when low), bus (slave: in_valid/in_code/in_ready, ack, y, busy, acked, timeout)
module onehot_dispatch_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  onehot_dispatch_decoder_if.slave bus
);
  localparam int MX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MX + 1) < 1 ? 1 : $clog2(MX + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = GAP_CYCLES > 0 ? CW'(GAP_CYCLES - 1) : '0;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] code;
  logic [7:0] y;
  logic acked, timeout;
  logic hit;
  assign hit = bus.ack[code];
  assign bus.in_ready = en && state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.y = y;
  assign bus.acked = acked;
  assign bus.timeout = timeout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y <= '0;
      acked <= 1'b0;
      timeout <= 1'b0;
      cnt <= '0;
      code <= '0;
    end else if (!en) begin
      state <= IDLE;
      y <= '0;
      acked <= 1'b0;
      timeout <= 1'b0;
      cnt <= '0;
    end else begin
      acked <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          code <= bus.in_code;
          y <= 8'b1 << bus.in_code;
          cnt <= HOLD_LD;
          state <= DRIVE;
        end
        DRIVE: if (hit || cnt == '0) begin
          y <= '0;
          acked <= hit;
          timeout <= !hit;
          cnt <= GAP_LD;
          state <= GAP_CYCLES > 0 ? GAP : IDLE;
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_onehot_dispatch_decoder.sv
// tb_onehot_dispatch_decoder: directed and randomized checks of two decoder configurations against a timeline model
module tb_onehot_dispatch_decoder;
  logic clk, rst_n, en;
  int n_chk = 0, n_fail = 0;
  onehot_dispatch_decoder_if if_a ();
  onehot_dispatch_decoder_if if_b ();
  onehot_dispatch_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_a (.clk(clk), .rst_n(rst_n), .en(en), .bus(if_a));
  onehot_dispatch_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (.clk(clk), .rst_n(rst_n), .en(en), .bus(if_b));
  initial clk = 0;
  always #5 clk = ~clk;
  int hold_c[2] = '{4, 1};
  int gap_c[2] = '{1, 0};
  int line[2] = '{-1, -1};
  int age[2] = '{0, 0};
  int gap_rem[2] = '{0, 0};
  logic m_acked[2] = '{0, 0};
  logic m_to[2] = '{0, 0};
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void release_line(int i);
    line[i] = -1;
    gap_rem[i] = gap_c[i];
  endfunction
  function automatic void step(int i, logic rn, logic e, logic v, logic [2:0] c, logic [7:0] a);
    m_acked[i] = 0;
    m_to[i] = 0;
    if (!rn || !e) begin
      line[i] = -1;
      gap_rem[i] = 0;
    end else if (line[i] >= 0) begin
      age[i]++;
      if (a[line[i]]) begin
        m_acked[i] = 1;
        release_line(i);
      end else if (age[i] >= hold_c[i]) begin
        m_to[i] = 1;
        release_line(i);
      end
    end else if (gap_rem[i] > 0) gap_rem[i]--;
    else if (v) begin
      line[i] = int'(c);
      age[i] = 0;
    end
  endfunction
  function automatic logic [7:0] m_y(int i);
    return line[i] >= 0 ? 8'h01 << line[i] : 8'h00;
  endfunction
  function automatic logic m_busy(int i);
    return line[i] >= 0 || gap_rem[i] > 0;
  endfunction
  task automatic cmp(int i, string nm, logic [7:0] y, logic r, logic b, logic ak, logic to);
    chk({nm, "_y"}, 32'(y), 32'(m_y(i)));
    chk({nm, "_ready"}, 32'(r), 32'(en && !m_busy(i)));
    chk({nm, "_busy"}, 32'(b), 32'(m_busy(i)));
    chk({nm, "_acked"}, 32'(ak), 32'(m_acked[i]));
    chk({nm, "_timeout"}, 32'(to), 32'(m_to[i]));
    chk({nm, "_onehot0"}, 32'($onehot0(y)), 32'd1);
  endtask
  always begin
    @(posedge clk);
    step(0, rst_n, en, if_a.in_valid, if_a.in_code, if_a.ack);
    step(1, rst_n, en, if_b.in_valid, if_b.in_code, if_b.ack);
    #1;
    cmp(0, "a", if_a.y, if_a.in_ready, if_a.busy, if_a.acked, if_a.timeout);
    cmp(1, "b", if_b.y, if_b.in_ready, if_b.busy, if_b.acked, if_b.timeout);
  end
  task automatic nx(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_a(logic [2:0] c);
    if_a.in_valid = 1;
    if_a.in_code = c;
    nx();
    if_a.in_valid = 0;
  endtask
  initial begin
    rst_n = 0;
    en = 1;
    if_a.in_valid = 0; if_a.in_code = 0; if_a.ack = 0;
    if_b.in_valid = 0; if_b.in_code = 0; if_b.ack = 0;
    nx(2);
    rst_n = 1;
    chk("reset_y", 32'(if_a.y), 32'h00);
    chk("reset_ready", 32'(if_a.in_ready), 32'd1);
    send_a(3);
    chk("to_y0", 32'(if_a.y), 32'h08);
    for (int i = 1; i <= 3; i++) begin
      nx();
      chk("to_y_hold", 32'(if_a.y), 32'h08);
      chk("to_no_pulse", 32'(if_a.timeout), 32'd0);
    end
    nx();
    chk("to_y_rel", 32'(if_a.y), 32'h00);
    chk("to_pulse", 32'(if_a.timeout), 32'd1);
    chk("to_gap_ready", 32'(if_a.in_ready), 32'd0);
    nx();
    chk("to_pulse_end", 32'(if_a.timeout), 32'd0);
    chk("to_ready", 32'(if_a.in_ready), 32'd1);
    send_a(6);
    chk("ack_y0", 32'(if_a.y), 32'h40);
    nx();
    chk("ack_y1", 32'(if_a.y), 32'h40);
    if_a.ack = 8'h40;
    nx();
    if_a.ack = 0;
    chk("ack_y_rel", 32'(if_a.y), 32'h00);
    chk("ack_pulse", 32'(if_a.acked), 32'd1);
    chk("ack_no_to", 32'(if_a.timeout), 32'd0);
    nx();
    chk("ack_pulse_end", 32'(if_a.acked), 32'd0);
    send_a(0);
    if_a.ack = 8'h02;
    nx(3);
    chk("wrong_ack_y", 32'(if_a.y), 32'h01);
    nx();
    chk("wrong_ack_to", 32'(if_a.timeout), 32'd1);
    chk("wrong_ack_noack", 32'(if_a.acked), 32'd0);
    if_a.ack = 0;
    nx();
    send_a(0);
    nx(3);
    if_a.ack = 8'h01;
    nx();
    if_a.ack = 0;
    chk("late_ack", 32'(if_a.acked), 32'd1);
    chk("late_no_to", 32'(if_a.timeout), 32'd0);
    nx();
    send_a(7);
    chk("abort_y0", 32'(if_a.y), 32'h80);
    nx();
    en = 0;
    if_a.in_valid = 1;
    if_a.in_code = 2;
    nx();
    chk("abort_y", 32'(if_a.y), 32'h00);
    chk("abort_no_pulse", 32'(if_a.acked | if_a.timeout), 32'd0);
    chk("abort_ready", 32'(if_a.in_ready), 32'd0);
    nx();
    chk("held_not_taken", 32'(if_a.y), 32'h00);
    en = 1;
    #1 chk("en_ready", 32'(if_a.in_ready), 32'd1);
    nx();
    if_a.in_valid = 0;
    chk("held_taken", 32'(if_a.y), 32'h04);
    nx(6);
    send_a(5);
    chk("rst_y0", 32'(if_a.y), 32'h20);
    #3 rst_n = 0;
    #1 chk("rst_async_y", 32'(if_a.y), 32'h00);
    chk("rst_async_busy", 32'(if_a.busy), 32'd0);
    nx();
    rst_n = 1;
    chk("rst_ready", 32'(if_a.in_ready), 32'd1);
    begin
      logic [7:0] exp_seq[5] = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h10};
      logic [2:0] codes[3] = '{3'd1, 3'd2, 3'd4};
      int tos = 0;
      if_b.in_valid = 1;
      if_b.in_code = codes[0];
      for (int k = 0; k < 5; k++) begin
        nx();
        if (k == 0) if_b.in_code = codes[1];
        if (k == 2) if_b.in_code = codes[2];
        if (k == 4) if_b.in_valid = 0;
        chk("stream_y", 32'(if_b.y), 32'(exp_seq[k]));
        tos += int'(if_b.timeout);
      end
      nx();
      tos += int'(if_b.timeout);
      chk("stream_timeouts", 32'(tos), 32'd3);
    end
    for (int k = 0; k < 400; k++) begin
      nx();
      en = ($urandom_range(0, 15) != 0);
      if_a.in_valid = 1'($urandom);
      if_a.in_code = 3'($urandom);
      if_a.ack = 8'($urandom & $urandom & $urandom);
      if_b.in_valid = 1'($urandom);
      if_b.in_code = 3'($urandom);
      if_b.ack = 8'($urandom & $urandom);
    end
    nx(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
